// File: rtl/ahb_apb_pkg.sv
// ahb_apb_pkg: encodings shared by the AHB front end and the APB controller.
//   HTRANS_*     : AHB transfer type codes
//   HRESP_*      : AHB response codes
//   bridge_state_e : AHB-side request FSM states
package ahb_apb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_DATA,
        ST_RD_PUSH,
        ST_RD_WAIT,
        ST_RD_DONE,
        ST_ERR1,
        ST_ERR2
    } bridge_state_e;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock in-order FIFO, synchronous active-low reset.
//   HCLK, HRESETn : clock / reset
//   push, wdata   : write an entry (ignored when full)
//   pop           : drop the head (ignored when empty)
//   rdata         : head entry, stable until popped
//   full, empty, count : occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       HCLK,
    input  logic                       HRESETn,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    // full/empty come from the registered count, so a pop this cycle never
    // makes room for a push in the same cycle
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/ahb_apb_req_queue.sv
// ahb_apb_req_queue: AHB-side front end of the AHB-APB bridge.
// Decodes HADDR into a one-hot APB slave select, queues writes and reads in
// order for the APB controller, stalls AHB while the queue is full or a read
// is outstanding, returns read data and issues two-cycle ERROR responses for
// selected-but-unmapped addresses.
//   HCLK, HRESETn        : clock, synchronous active-low reset
//   HSEL..HWDATA         : AHB slave inputs
//   HREADYout/HRESP/HRDATA : AHB slave response
//   REQ_*                : queue head towards the APB controller (REQ_READY pops)
//   RD_VALID, RD_DATA    : read data coming back from APB
module ahb_apb_req_queue
    import ahb_apb_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                NUM_SLV    = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int                SLV_SHIFT  = 26,
    parameter int                FIFO_DEPTH = 4
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic              HWRITE,
    input  logic              HREADYin,
    input  logic [1:0]        HTRANS,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [DATA_W-1:0] HWDATA,
    output logic              HREADYout,
    output logic              HRESP,
    output logic [DATA_W-1:0] HRDATA,
    output logic              REQ_VALID,
    input  logic              REQ_READY,
    output logic              REQ_WRITE,
    output logic [ADDR_W-1:0] REQ_ADDR,
    output logic [DATA_W-1:0] REQ_WDATA,
    output logic [NUM_SLV-1:0] REQ_SEL,
    input  logic              RD_VALID,
    input  logic [DATA_W-1:0] RD_DATA
);

    localparam int ENT_W = 1 + ADDR_W + DATA_W + NUM_SLV;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    bridge_state_e      state, state_nxt;
    logic [ADDR_W-1:0]  addr_reg;
    logic [NUM_SLV-1:0] sel_reg;

    // ---------------- address decode ----------------
    logic [ADDR_W-1:0]  offset;
    logic [ADDR_W-1:0]  idx;
    logic               mapped;
    logic [NUM_SLV-1:0] dec_sel;

    assign offset = HADDR - BASE_ADDR;
    assign idx    = offset >> SLV_SHIFT;
    // the subtraction wraps for addresses below the base, so check that first
    assign mapped = (HADDR >= BASE_ADDR) && (idx < ADDR_W'(NUM_SLV));

    genvar g;
    generate
        for (g = 0; g < NUM_SLV; g++) begin : g_dec
            assign dec_sel[g] = mapped && (idx == ADDR_W'(g));
        end
    endgenerate

    // ---------------- request queue ----------------
    logic             fifo_push;
    logic [ENT_W-1:0] fifo_wdata;
    logic [ENT_W-1:0] fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .push    (fifo_push),
        .wdata   (fifo_wdata),
        .pop     (REQ_READY && !fifo_empty),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign REQ_VALID = (fifo_count != '0);
    assign {REQ_WRITE, REQ_ADDR, REQ_WDATA, REQ_SEL} = fifo_rdata;

    // ---------------- FSM ----------------
    logic addr_ok;
    logic take;

    // an active (NONSEQ/SEQ) transfer addressed to us on a ready bus
    assign addr_ok = HREADYin && HSEL &&
                     ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

    always_comb begin
        state_nxt  = state;
        HREADYout  = 1'b1;
        HRESP      = HRESP_OKAY;
        fifo_push  = 1'b0;
        fifo_wdata = '0;
        take       = 1'b0;
        case (state)
            ST_IDLE: begin
                take = addr_ok;
            end
            ST_WR_DATA: begin
                // data phase completes only once the entry can be queued;
                // while stalled the master holds HWDATA and the next address
                HREADYout = !fifo_full;
                if (!fifo_full) begin
                    fifo_push  = 1'b1;
                    fifo_wdata = {1'b1, addr_reg, HWDATA, sel_reg};
                    take       = addr_ok;
                    state_nxt  = ST_IDLE;
                end
            end
            ST_RD_PUSH: begin
                HREADYout = 1'b0;
                if (!fifo_full) begin
                    fifo_push  = 1'b1;
                    fifo_wdata = {1'b0, addr_reg, {DATA_W{1'b0}}, sel_reg};
                    state_nxt  = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                HREADYout = 1'b0;
                if (RD_VALID) state_nxt = ST_RD_DONE;
            end
            ST_RD_DONE: begin
                take      = addr_ok;
                state_nxt = ST_IDLE;
            end
            ST_ERR1: begin
                HREADYout = 1'b0;
                HRESP     = HRESP_ERROR;
                state_nxt = ST_ERR2;
            end
            ST_ERR2: begin
                HRESP     = HRESP_ERROR;
                take      = addr_ok;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (take) begin
            if (!mapped)     state_nxt = ST_ERR1;
            else if (HWRITE) state_nxt = ST_WR_DATA;
            else             state_nxt = ST_RD_PUSH;
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state    <= ST_IDLE;
            addr_reg <= '0;
            sel_reg  <= '0;
            HRDATA   <= '0;
        end else begin
            state <= state_nxt;
            if (take) begin
                addr_reg <= HADDR;
                sel_reg  <= dec_sel;
            end
            // read data is only accepted while a read is outstanding
            if (state == ST_RD_WAIT && RD_VALID) HRDATA <= RD_DATA;
        end
    end

endmodule

// File: tb/tb_ahb_apb_req_queue.sv
// Self-checking bench for ahb_apb_req_queue: directed scenarios followed by a
// randomized transfer mix, with queue contents checked against a reference
// list built from the address map rules.
module tb_ahb_apb_req_queue;

    localparam logic [31:0] BASE    = 32'h8000_0000;
    localparam logic [31:0] SLV_SZ  = 32'h0400_0000;

    typedef logic [67:0] ent_t;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        HSEL = 1'b0;
    logic        HWRITE = 1'b0;
    logic        HREADYin;
    logic [1:0]  HTRANS = 2'b00;
    logic [31:0] HADDR = '0;
    logic [31:0] HWDATA = '0;
    logic        HREADYout;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic        REQ_WRITE;
    logic [31:0] REQ_ADDR;
    logic [31:0] REQ_WDATA;
    logic [2:0]  REQ_SEL;
    logic        RD_VALID = 1'b0;
    logic [31:0] RD_DATA = '0;

    logic rr_rand = 1'b0;
    logic rr_rnd  = 1'b0;
    logic rr_dir  = 1'b0;

    assign HREADYin  = HREADYout;
    assign REQ_READY = rr_rand ? rr_rnd : rr_dir;

    always #5 HCLK = ~HCLK;

    ahb_apb_req_queue dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HWRITE    (HWRITE),
        .HREADYin  (HREADYin),
        .HTRANS    (HTRANS),
        .HADDR     (HADDR),
        .HWDATA    (HWDATA),
        .HREADYout (HREADYout),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .REQ_VALID (REQ_VALID),
        .REQ_READY (REQ_READY),
        .REQ_WRITE (REQ_WRITE),
        .REQ_ADDR  (REQ_ADDR),
        .REQ_WDATA (REQ_WDATA),
        .REQ_SEL   (REQ_SEL),
        .RD_VALID  (RD_VALID),
        .RD_DATA   (RD_DATA)
    );

    // random APB-side back-pressure
    always begin
        @(posedge HCLK);
        #1;
        rr_rnd = ($urandom_range(0, 3) != 0);
    end

    // entries actually handed to APB, in pop order
    ent_t got [512];
    int   got_n   = 0;
    int   rd_pops = 0;

    always @(negedge HCLK) begin
        if (HRESETn && REQ_VALID && REQ_READY && got_n < 512) begin
            got[got_n] = {REQ_WRITE, REQ_ADDR, REQ_WDATA, REQ_SEL};
            got_n++;
            if (!REQ_WRITE) rd_pops++;
        end
    end

    // reference: entries that should be queued, in AHB order
    ent_t expq [512];
    int   exp_n = 0;
    int   cmp_k = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    function automatic logic [2:0] sel_of(input logic [31:0] a);
        int unsigned slot;
        slot = (a - BASE) / SLV_SZ;
        if (a < BASE || slot >= 3) return 3'b000;
        return 3'(1 << slot);
    endfunction

    function automatic logic [31:0] rand_mapped();
        return BASE + $urandom_range(0, 2) * SLV_SZ + ($urandom & 32'h03FF_FFFC);
    endfunction

    task automatic expect_push(input logic w, input logic [31:0] a, input logic [31:0] d);
        expq[exp_n] = {w, a, (w ? d : 32'h0), sel_of(a)};
        exp_n++;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // wait (bounded) for a cycle with HREADYout high, then let its edge pass
    task automatic wait_ready(input string tag);
        int k;
        k = 0;
        @(negedge HCLK);
        while (!HREADYout && k < 300) begin
            @(negedge HCLK);
            k++;
        end
        if (!HREADYout) chk({tag, "_timeout"}, HREADYout, 1'b1);
        tick();
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while (got_n < exp_n && k < 600) begin
            @(negedge HCLK);
            k++;
        end
        repeat (3) @(negedge HCLK);
        chk({tag, "_count"}, got_n, exp_n);
        for (int i = cmp_k; i < exp_n && i < got_n; i++)
            chk({tag, "_entry"}, got[i], expq[i]);
        cmp_k = exp_n;
        tick();
    endtask

    task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
        HSEL = 1'b1; HWRITE = 1'b1; HTRANS = 2'b10; HADDR = a;
        wait_ready("wr_addr");
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = d;
        expect_push(1'b1, a, d);
        wait_ready("wr_data");
    endtask

    task automatic ahb_read(input logic [31:0] a, input logic [31:0] d, input int dly);
        int base;
        int k;
        HSEL = 1'b1; HWRITE = 1'b0; HTRANS = 2'b10; HADDR = a;
        wait_ready("rd_addr");
        HSEL = 1'b0; HTRANS = 2'b00;
        expect_push(1'b0, a, 32'h0);
        base = rd_pops;
        k = 0;
        while (rd_pops == base && k < 600) begin
            @(negedge HCLK);
            k++;
        end
        if (rd_pops == base) chk("rd_pop_timeout", rd_pops, base + 1);
        tick();
        repeat (dly) tick();
        RD_VALID = 1'b1; RD_DATA = d;
        @(negedge HCLK);
        chk("rd_wait_hready", HREADYout, 1'b0);
        tick();
        RD_VALID = 1'b0; RD_DATA = $urandom;
        @(negedge HCLK);
        chk("rd_done_hready", HREADYout, 1'b1);
        chk("rd_done_hresp", HRESP, 1'b0);
        chk("rd_done_hrdata", HRDATA, d);
        tick();
    endtask

    task automatic ahb_err(input logic [31:0] a);
        HSEL = 1'b1; HWRITE = 1'($urandom_range(0, 1)); HTRANS = 2'b10; HADDR = a;
        wait_ready("err_addr");
        HSEL = 1'b0; HTRANS = 2'b00;
        @(negedge HCLK);
        chk("err1_hready", HREADYout, 1'b0);
        chk("err1_hresp", HRESP, 1'b1);
        tick();
        @(negedge HCLK);
        chk("err2_hready", HREADYout, 1'b1);
        chk("err2_hresp", HRESP, 1'b1);
        tick();
        @(negedge HCLK);
        chk("err_after_hready", HREADYout, 1'b1);
        chk("err_after_hresp", HRESP, 1'b0);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;

        // ---- reset with an active transfer on the bus ----
        HRESETn = 1'b0; HSEL = 1'b1; HWRITE = 1'b1; HTRANS = 2'b10; HADDR = BASE;
        repeat (2) begin
            @(negedge HCLK);
            chk("rst_hready", HREADYout, 1'b1);
            chk("rst_hresp", HRESP, 1'b0);
            chk("rst_reqvalid", REQ_VALID, 1'b0);
            chk("rst_hrdata", HRDATA, 32'h0);
        end
        tick();
        HSEL = 1'b0; HTRANS = 2'b00;
        HRESETn = 1'b1;
        tick();
        @(negedge HCLK);
        chk("rst_no_push", REQ_VALID, 1'b0);
        tick();

        // ---- single write: decode and two-cycle queue latency ----
        rr_dir = 1'b0;
        HSEL = 1'b1; HWRITE = 1'b1; HTRANS = 2'b10; HADDR = 32'h8400_0010;
        wait_ready("w1_addr");
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'hDEAD_BEEF;
        expect_push(1'b1, 32'h8400_0010, 32'hDEAD_BEEF);
        @(negedge HCLK);
        chk("w1_valid_n1", REQ_VALID, 1'b0);
        chk("w1_hready", HREADYout, 1'b1);
        tick();
        @(negedge HCLK);
        chk("w1_valid_n2", REQ_VALID, 1'b1);
        chk("w1_sel", REQ_SEL, 3'b010);
        chk("w1_wdata", REQ_WDATA, 32'hDEAD_BEEF);
        chk("w1_addr", REQ_ADDR, 32'h8400_0010);
        chk("w1_write", REQ_WRITE, 1'b1);
        tick();
        @(negedge HCLK);
        chk("w1_hold_valid", REQ_VALID, 1'b1);
        chk("w1_hold_wdata", REQ_WDATA, 32'hDEAD_BEEF);
        tick();
        rr_dir = 1'b1;
        drain("w1");

        // ---- 5-beat write burst into a depth-4 queue with APB stalled ----
        rr_dir = 1'b0;
        HSEL = 1'b1; HWRITE = 1'b1; HTRANS = 2'b10; HADDR = 32'h8000_0100;
        wait_ready("burst_a0");
        for (int i = 1; i < 5; i++) begin
            HTRANS = 2'b11;
            HADDR  = 32'h8000_0100 + 32'(4 * i);
            HWDATA = 32'hB000_0000 + 32'(i - 1);
            expect_push(1'b1, 32'h8000_0100 + 32'(4 * (i - 1)), HWDATA);
            wait_ready("burst_beat");
        end
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'hB000_0004;
        expect_push(1'b1, 32'h8000_0110, 32'hB000_0004);
        @(negedge HCLK);
        chk("burst_5th_stall", HREADYout, 1'b0);
        tick();
        @(negedge HCLK);
        chk("burst_5th_stall2", HREADYout, 1'b0);
        chk("burst_head_addr", REQ_ADDR, 32'h8000_0100);
        chk("burst_head_data", REQ_WDATA, 32'hB000_0000);
        tick();
        rr_dir = 1'b1;
        wait_ready("burst_5th_done");
        drain("burst");

        // ---- write then read: read queued behind the write ----
        rr_dir = 1'b1;
        ahb_write(32'h8000_0000, 32'hA5A5_0001);
        ahb_read(32'h8800_0004, 32'h0000_1234, 3);
        drain("wr_rd");

        // ---- unmapped address inside the bridge window ----
        ahb_err(32'h8C00_0000);
        @(negedge HCLK);
        chk("err_fifo_untouched", REQ_VALID, 1'b0);
        tick();
        drain("err");

        // ---- reset while a read is outstanding with two entries queued ----
        rr_dir = 1'b0;
        ahb_write(32'h8400_0020, 32'h5555_AAAA);
        HSEL = 1'b1; HWRITE = 1'b0; HTRANS = 2'b10; HADDR = 32'h8000_0008;
        wait_ready("rst_rd_addr");
        HSEL = 1'b0; HTRANS = 2'b00;
        tick();
        @(negedge HCLK);
        chk("rdwait_hready", HREADYout, 1'b0);
        chk("rdwait_queued", REQ_VALID, 1'b1);
        tick();
        HRESETn = 1'b0; HSEL = 1'b1; HTRANS = 2'b10;
        tick();
        tick();
        HSEL = 1'b0; HTRANS = 2'b00;
        HRESETn = 1'b1;
        exp_n = cmp_k;
        @(negedge HCLK);
        chk("rst2_reqvalid", REQ_VALID, 1'b0);
        chk("rst2_hready", HREADYout, 1'b1);
        chk("rst2_hresp", HRESP, 1'b0);
        chk("rst2_hrdata", HRDATA, 32'h0);
        tick();
        RD_VALID = 1'b1; RD_DATA = 32'hFFFF_0BAD;
        tick();
        RD_VALID = 1'b0;
        @(negedge HCLK);
        chk("stray_hrdata", HRDATA, 32'h0);
        chk("stray_hready", HREADYout, 1'b1);
        chk("stray_reqvalid", REQ_VALID, 1'b0);
        tick();
        rr_dir = 1'b1;
        drain("rst2");

        // ---- randomized transfer mix with random APB back-pressure ----
        rr_rand = 1'b1;
        for (int it = 0; it < 40; it++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op <= 3) begin
                ahb_write(rand_mapped(), $urandom);
            end else if (op <= 6) begin
                ahb_read(rand_mapped(), $urandom, $urandom_range(0, 3));
            end else if (op == 7) begin
                if ($urandom_range(0, 1) == 1) a = $urandom & 32'h7FFF_FFFF;
                else                           a = 32'h8C00_0000 + ($urandom & 32'h73FF_FFFF);
                ahb_err(a);
            end else if (op == 8) begin
                HSEL = 1'b1; HWRITE = 1'($urandom_range(0, 1));
                HTRANS = 2'($urandom_range(0, 1)); HADDR = rand_mapped();
                tick();
                HSEL = 1'b0; HTRANS = 2'b00;
                @(negedge HCLK);
                chk("idlebusy_hready", HREADYout, 1'b1);
                chk("idlebusy_hresp", HRESP, 1'b0);
                tick();
            end else begin
                d = 32'($urandom_range(1, 3));
                repeat (d) tick();
            end
        end
        drain("rand");
        repeat (5) tick();
        chk("final_no_extra_pops", got_n, exp_n);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
